// File: rtl/cycle_sequencer_pkg.sv
// Shared encodings and constants for the CPU cycle sequencer and its interrupt priority encoder.
package cycle_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1,
    ST_DISPATCH = 2'd2
  } seq_state_t;

  localparam logic [3:0] STEP_RESET       = 4'b0001;
  localparam logic [7:0] COUNT_RESET      = 8'h01;
  localparam logic [7:0] INT_VECTOR_BASE  = 8'h40;
  localparam int         DISPATCH_MCYCLES = 5;
  localparam int         ACK_MCYCLE       = 3;
  localparam int         N_INT            = 5;

  // Restart addresses are spaced eight bytes apart above the base.
  function automatic logic [7:0] int_vector(input logic [2:0] idx);
    return INT_VECTOR_BASE + {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/cycle_sequencer_int_priority.sv
// Combinational lowest-set-bit encoder for pending interrupts; bit 0 has the highest priority.
module int_priority
  import cycle_sequencer_pkg::*;
(
  input  logic [N_INT-1:0] req,
  output logic [N_INT-1:0] grant,
  output logic [2:0]       index,
  output logic             any
);

  // Scanning from the top lets the lowest set bit overwrite any higher one.
  always_comb begin
    grant = '0;
    index = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = 3'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle sequencer with HALT and interrupt dispatch; all outputs registered
// except the restart vector, which is decoded from the source latched at dispatch entry.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int N_MCYCLE_MAX = 8
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Fetch,
  input  logic                    i_Halt,
  input  logic                    i_Stall,
  input  logic                    i_EI,
  input  logic                    i_EI_Now,
  input  logic                    i_DI,
  input  logic [N_INT-1:0]        i_IE,
  input  logic [N_INT-1:0]        i_IF,
  output logic [3:0]              o_Cycle_Step,
  output logic [N_MCYCLE_MAX-1:0] o_Cycle_Count,
  output logic                    o_IME,
  output logic                    o_Halted,
  output logic                    o_Int_Dispatch,
  output logic [N_INT-1:0]        o_Int_Ack,
  output logic [7:0]              o_Int_Vector
);

  localparam logic [N_MCYCLE_MAX-1:0] CNT_INIT = N_MCYCLE_MAX'(COUNT_RESET);

  seq_state_t              state, next_state;
  logic [3:0]              step, step_d;
  logic [N_MCYCLE_MAX-1:0] count, count_d;
  logic                    ime, ime_d;
  logic                    ei_pending, ei_pending_d;
  logic [N_INT-1:0]        src_grant;
  logic [2:0]              src_idx;
  logic                    halted_d, dispatch_d;
  logic [N_INT-1:0]        ack, ack_d;
  logic                    halted, int_dispatch;

  logic [N_INT-1:0]        pend_grant;
  logic [2:0]              pend_idx;
  logic                    pend_any;
  logic                    m_end, dispatch_last, boundary, dispatch_entry;

  int_priority u_int_priority (
    .req   (i_IE & i_IF),
    .grant (pend_grant),
    .index (pend_idx),
    .any   (pend_any)
  );

  assign m_end          = step[3] && !i_Stall;
  assign dispatch_last  = count[DISPATCH_MCYCLES-1];
  assign boundary       = m_end && (((state == ST_RUN) && i_Fetch) ||
                                    ((state == ST_DISPATCH) && dispatch_last));
  assign dispatch_entry = (state != ST_DISPATCH) && (next_state == ST_DISPATCH);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= ST_RUN;
      step         <= STEP_RESET;
      count        <= CNT_INIT;
      ime          <= 1'b0;
      ei_pending   <= 1'b0;
      src_grant    <= '0;
      src_idx      <= '0;
      halted       <= 1'b0;
      int_dispatch <= 1'b0;
      ack          <= '0;
    end else begin
      state        <= next_state;
      step         <= step_d;
      count        <= count_d;
      ime          <= ime_d;
      ei_pending   <= ei_pending_d;
      halted       <= halted_d;
      int_dispatch <= dispatch_d;
      ack          <= ack_d;
      if (dispatch_entry) begin
        src_grant <= pend_grant;
        src_idx   <= pend_idx;
      end
    end
  end

  // Dispatch entry tests the IME value from before this boundary's EI promotion.
  always_comb begin
    next_state = state;
    if (m_end) begin
      unique case (state)
        ST_RUN: begin
          if (i_Fetch) begin
            if (ime && pend_any) next_state = ST_DISPATCH;
            else if (i_Halt)     next_state = ST_HALT;
          end
        end
        ST_HALT:     if (pend_any) next_state = ime ? ST_DISPATCH : ST_RUN;
        ST_DISPATCH: if (dispatch_last) next_state = ST_RUN;
        default:     next_state = ST_RUN;
      endcase
    end
  end

  always_comb begin
    step_d  = i_Stall ? step : {step[2:0], step[3]};
    count_d = count;
    if (m_end) begin
      if (boundary || (state == ST_HALT)) count_d = CNT_INIT;
      else if (!count[N_MCYCLE_MAX-1])    count_d = count << 1;
    end

    halted_d   = (next_state == ST_HALT);
    dispatch_d = (next_state == ST_DISPATCH);
    // Registered so the pulse coincides with the M3 step-1000 state.
    ack_d = ((state == ST_DISPATCH) && !i_Stall && step[2] && count[ACK_MCYCLE-1])
            ? src_grant : '0;

    ime_d        = ime;
    ei_pending_d = ei_pending;
    if (boundary && (state == ST_RUN)) begin
      ei_pending_d = 1'b0;
      if (ei_pending) ime_d = 1'b1;
    end
    if (dispatch_entry) ime_d        = 1'b0;
    if (i_EI)           ei_pending_d = 1'b1;
    if (i_EI_Now)       ime_d        = 1'b1;
    if (i_DI) begin
      ime_d        = 1'b0;
      ei_pending_d = 1'b0;
    end
  end

  assign o_Cycle_Step   = step;
  assign o_Cycle_Count  = count;
  assign o_IME          = ime;
  assign o_Halted       = halted;
  assign o_Int_Dispatch = int_dispatch;
  assign o_Int_Ack      = ack;
  assign o_Int_Vector   = int_dispatch ? int_vector(src_idx) : 8'h00;

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter N_MCYCLE_MAX, default 8, the width of the one-hot M-cycle counter.
REQ-002 SHALL have port i_Clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_Reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port i_Fetch, input, 1 bit: the decoders request "instruction ends this M-cycle".
REQ-005 SHALL have port i_Halt, input, 1 bit: HALT decoded, sampled only at an instruction boundary.
REQ-006 SHALL have port i_Stall, input, 1 bit: memory wait; freezes all sequencing.
REQ-007 SHALL have ports i_EI, i_EI_Now and i_DI, inputs, 1 bit each: delayed enable (EI), immediate enable (RETI), disable (DI).
REQ-008 SHALL have ports i_IE and i_IF, inputs, 5 bits each: interrupt enable and interrupt flag bits.
REQ-009 SHALL have port o_Cycle_Step, output, 4 bits: one-hot T-state within the M-cycle.
REQ-010 SHALL have port o_Cycle_Count, output, 8 bits: one-hot M-cycle index within the instruction or dispatch.
REQ-011 SHALL have ports o_IME (interrupt master enable), o_Halted and o_Int_Dispatch, outputs, 1 bit each.
REQ-012 SHALL have ports o_Int_Ack (5 bits, one-hot IF clear pulse) and o_Int_Vector (8 bits, restart address low byte), outputs.

Function
REQ-013 o_Cycle_Step SHALL rotate 0001->0010->0100->1000->0001 once per clock while i_Stall=0, and SHALL hold while i_Stall=1.
REQ-014 "Boundary" SHALL mean step=1000, i_Stall=0 and (state RUN with i_Fetch=1, or state DISPATCH at M5).
REQ-015 At a step 1000->0001 transition that is not a boundary, o_Cycle_Count SHALL shift left one bit; at bit 7 it SHALL saturate (hold).
REQ-016 At every boundary o_Cycle_Count SHALL reload 8'h01.
REQ-017 The states SHALL be RUN, HALT and DISPATCH.
REQ-018 At a RUN boundary: if IME=1 and |(i_IE&i_IF), the next state SHALL be DISPATCH; else if i_Halt=1, HALT; else RUN.
REQ-019 Dispatch entry SHALL take priority over i_Halt when both are true at the same boundary.
REQ-020 HALT: step SHALL keep rotating, count SHALL hold 8'h01, and o_Halted=1.
REQ-021 HALT exit: at step 1000, when |(i_IE&i_IF), the next state SHALL be DISPATCH if IME=1, else RUN; this exit is independent of IME.
REQ-022 DISPATCH: SHALL last exactly 5 M-cycles (count 01..10h) with o_Int_Dispatch=1; IME SHALL clear on entry.
REQ-023 DISPATCH: the serviced source SHALL be the lowest set bit of i_IE&i_IF, latched at entry (bit0 = highest priority).
REQ-024 o_Int_Vector SHALL equal 8'h40 + 8*n for latched source n, and SHALL be valid throughout DISPATCH (8'h00 otherwise).
REQ-025 o_Int_Ack SHALL pulse the latched one-hot bit for exactly one clock, at M3 step 1000.
REQ-026 If the latched source is gone (IF cleared externally) at entry, dispatch SHALL still run all 5 M-cycles with the latched vector.
REQ-027 i_EI SHALL set ei_pending; at the next RUN boundary ei_pending SHALL move to IME.
REQ-028 The dispatch decision at that boundary SHALL use the pre-update IME, giving a one-instruction EI delay.
REQ-029 i_EI_Now SHALL set IME on the next clock; i_DI SHALL clear IME and ei_pending on the next clock.
REQ-030 When i_DI and i_EI or i_EI_Now are asserted together, i_DI SHALL win.
REQ-031 i_Stall=1 SHALL freeze state, count, step and dispatch progress; o_Int_Ack SHALL never fire while stalled.
REQ-032 Outputs SHALL be registered, except o_Int_Vector, which is decoded from the latched source.

Reset
REQ-033 When i_Reset=1 at a clock edge: step=0001, count=8'h01, state=RUN, IME=0, ei_pending=0, latched source cleared.
REQ-034 On the same reset edge: o_Halted=0, o_Int_Dispatch=0, o_Int_Ack=0, o_Int_Vector=0.
REQ-035 Reset SHALL override i_Stall and abort DISPATCH or HALT mid-operation, with no ack issued.

Structure
REQ-036 A shared package SHALL hold the state encoding, STEP_RESET=4'b0001, COUNT_RESET=8'h01, INT_VECTOR_BASE=8'h40 and DISPATCH_MCYCLES=5.
REQ-037 One sub-module, int_priority, SHALL implement the combinational lowest-set-bit encoder (5-bit one-hot plus 3-bit index); the rest SHALL be flat.

Verification
REQ-038 Reset, then 12 clocks with i_Fetch at every M-cycle end -> step rotates, count stays 01; with i_Fetch low for 10 M-cycles, count walks 01..80 and holds at 80.
REQ-039 IME=1, i_IE=1F, i_IF=06 at a boundary -> DISPATCH for 20 clocks, o_Int_Ack=02 at M3 step 1000 only, o_Int_Vector=48, IME=0 afterwards.
REQ-040 i_EI during instruction A -> at the end of A no dispatch occurs despite a pending IF&IE=01; at the end of the following instruction B, dispatch with vector 40.
REQ-041 HALT with IME=0, then i_IF=10 and i_IE=10 -> o_Halted drops, state RUN, no ack; repeat with IME=1 -> DISPATCH with vector 60.
REQ-042 i_Stall held 7 clocks during DISPATCH M3 -> step, count and ack are delayed exactly 7 clocks; i_Reset at M4 -> all outputs at reset values next clock.
REQ-043 i_DI and i_EI_Now in the same clock -> IME=0.
